alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-side master for the ALU/register-file block: accepts buffered commands over a valid/ready channel and drives op, write data and the three register addresses.
- Waits a fixed result latency, then samples reg_read_data and alu_flags and returns them on a valid/ready response channel.
- Sits between the host/test harness (or a future instruction fetch unit) and the ALU/register wrapper.
- Serialises accesses so only one op is in flight.

Parameters:
DATA_WIDTH, 16, width of op, write data and read data
CMD_DEPTH, 4, command FIFO depth in entries (power of two, >=2)
RESULT_LATENCY, 1, cycles from op issue to valid reg_read_data/alu_flags (>=1)
NOP_OP, 16'hF000, op value driven whenever no command is being issued
TAG_WIDTH, 4, width of the pass-through command tag

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (high iff not full)
cmd_op  in  DATA_WIDTH  op to issue
cmd_data  in  DATA_WIDTH  external write data
cmd_addr_1  in  4  source address 1
cmd_addr_2  in  4  source address 2
cmd_addr_3  in  4  destination/read address
cmd_tag  in  TAG_WIDTH  returned unchanged with response
op  out  DATA_WIDTH  to ALU/register block
reg_write_data  out  DATA_WIDTH  to ALU/register block
alu_addr_1  out  4  to ALU/register block
alu_addr_2  out  4  to ALU/register block
alu_addr_3  out  4  to ALU/register block
reg_read_data  in  DATA_WIDTH  from ALU/register block
alu_flags  in  4  from ALU/register block
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_WIDTH  sampled reg_read_data
rsp_flags  out  4  sampled alu_flags
rsp_tag  out  TAG_WIDTH  tag of the completed command
busy  out  1  FSM not IDLE or FIFO non-empty
cmd_count  out  $clog2(CMD_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous and active-high:
  - FIFO emptied; cmd_count=0; cmd_ready=1.
  - FSM=IDLE.
  - op=NOP_OP; reg_write_data=0; alu_addr_1/2/3=0.
  - rsp_valid=0; rsp_data/flags/tag=0; busy=0.
- Reset mid-operation aborts the in-flight command and any held response. The op is returned to NOP_OP on the cycle after reset is sampled.
- Command FIFO:
  - Push on cmd_valid&&cmd_ready. cmd_ready=(cmd_count!=CMD_DEPTH), computed from registered count only. There is no push-through when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into issue registers and go to ISSUE on the next edge.
  - ISSUE: drive the registered op/data/addresses for exactly one cycle, load wait counter = RESULT_LATENCY-1, then go to WAIT.
  - WAIT:
    - Addresses and reg_write_data are held.
    - op returns to NOP_OP, so a write op is issued exactly once.
    - Counter decrements each cycle. At 0, go to CAPTURE.
    - With RESULT_LATENCY=1, WAIT lasts one cycle.
  - CAPTURE:
    - Sample reg_read_data and alu_flags into rsp_data/rsp_flags, and the tag into rsp_tag.
    - Set rsp_valid and go to RESP.
    - Address outputs stay held through this cycle.
  - RESP:
    - Hold all rsp_* stable while rsp_valid&&!rsp_ready.
    - On rsp_ready, clear rsp_valid. Go to IDLE, or directly pop the next command and go to ISSUE if the FIFO is non-empty (back-to-back issue).
- Timing: minimum command-to-command spacing is RESULT_LATENCY+3 cycles. Issue-to-rsp_valid latency is RESULT_LATENCY+1 cycles.
- Output registers: all outputs to the ALU/register block are registered. Nothing is combinationally forwarded from cmd_*.
- Response backpressure: the FSM stalls in RESP while the FIFO keeps accepting until full.
- busy = (state!=IDLE) || (cmd_count!=0).
- No arithmetic on data: values are passed through unmodified at full DATA_WIDTH.

Test Plan:
- Reset then idle 10 cycles -> op=16'hF000, cmd_ready=1, rsp_valid=0, busy=0, cmd_count=0.
- Non-ALU write: cmd_op=16'h1000, cmd_data=16'h00AB, addr_3=4'h5, tag=3; then read command op=16'h2000, addr_3=5, tag=4 (model returns stored value after 1 cycle):
  - Write response: rsp_tag=3.
  - Read response: rsp_data=16'h00AB, rsp_tag=4.
  - op asserted exactly one cycle per command.
- ALU op: op=16'h0000, addr_1=1 (=3), addr_2=2 (=4), addr_3=6, model flags=4'b0010 -> rsp_flags=4'b0010 captured at issue+2 cycles; addresses stable from ISSUE through CAPTURE.
- Backpressure/full:
  - Hold rsp_ready=0 and push 6 commands.
  - Required: first command reaches RESP; the FIFO then accepts CMD_DEPTH=4 more; cmd_ready=0 with cmd_count=4.
  - Release rsp_ready: all 5 accepted responses are returned in order with tags intact; the 6th command is accepted once space frees.
- Reset mid-WAIT with rsp pending and 2 queued -> next cycle rsp_valid=0, cmd_count=0, op=NOP_OP, FSM IDLE; no further responses.
- RESULT_LATENCY=3 build: issue to rsp_valid = 4 cycles; back-to-back spacing = 6 cycles with rsp_ready tied high.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the ALU/register block: queues commands, issues one at a
// time, waits the result latency and returns the sampled result on a response channel.
module alu_cmd_sequencer #(
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           CMD_DEPTH      = 4,
  parameter int unsigned           RESULT_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_OP         = DATA_WIDTH'(16'hF000),
  parameter int unsigned           TAG_WIDTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DATA_WIDTH-1:0]         cmd_op,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  input  logic [3:0]                    cmd_addr_1,
  input  logic [3:0]                    cmd_addr_2,
  input  logic [3:0]                    cmd_addr_3,
  input  logic [TAG_WIDTH-1:0]          cmd_tag,
  output logic [DATA_WIDTH-1:0]         op,
  output logic [DATA_WIDTH-1:0]         reg_write_data,
  output logic [3:0]                    alu_addr_1,
  output logic [3:0]                    alu_addr_2,
  output logic [3:0]                    alu_addr_3,
  input  logic [DATA_WIDTH-1:0]         reg_read_data,
  input  logic [3:0]                    alu_flags,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [3:0]                    rsp_flags,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic                          busy,
  output logic [$clog2(CMD_DEPTH):0]    cmd_count
);

  localparam int unsigned PTR_W   = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned WAIT_W  = $clog2(RESULT_LATENCY + 1);
  localparam int unsigned ENTRY_W = 2 * DATA_WIDTH + 12 + TAG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t                 state_q;
  logic [ENTRY_W-1:0]     fifo_q [CMD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic [WAIT_W-1:0]      wait_q;
  logic [DATA_WIDTH-1:0]  op_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [3:0]             addr1_q;
  logic [3:0]             addr2_q;
  logic [3:0]             addr3_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_data_q;
  logic [3:0]             rsp_flags_q;
  logic [TAG_WIDTH-1:0]   rsp_tag_q;

  logic                   push_c;
  logic                   pop_c;
  logic [DATA_WIDTH-1:0]  h_op;
  logic [DATA_WIDTH-1:0]  h_data;
  logic [3:0]             h_addr1;
  logic [3:0]             h_addr2;
  logic [3:0]             h_addr3;
  logic [TAG_WIDTH-1:0]   h_tag;

  // Ready depends on the registered count only: no push-through when full.
  assign cmd_ready = (count_q != CNT_W'(CMD_DEPTH));
  assign push_c    = cmd_valid && cmd_ready;
  assign pop_c     = (count_q != '0) &&
                     ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
  assign {h_op, h_data, h_addr1, h_addr2, h_addr3, h_tag} = fifo_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      op_q        <= NOP_OP;
      wdata_q     <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      addr3_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_addr_1, cmd_addr_2, cmd_addr_3, cmd_tag};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;

      case (state_q)
        S_IDLE: begin
          state_q <= S_IDLE;
        end
        // Op is presented for exactly one cycle; addresses/data stay held.
        S_ISSUE: begin
          op_q    <= NOP_OP;
          wait_q  <= WAIT_W'(RESULT_LATENCY - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_CAPTURE;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        S_CAPTURE: begin
          rsp_data_q  <= reg_read_data;
          rsp_flags_q <= alu_flags;
          rsp_tag_q   <= tag_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Popping from IDLE or an accepted RESP loads the issue registers directly.
      if (pop_c) begin
        op_q    <= h_op;
        wdata_q <= h_data;
        addr1_q <= h_addr1;
        addr2_q <= h_addr2;
        addr3_q <= h_addr3;
        tag_q   <= h_tag;
        state_q <= S_ISSUE;
      end
    end
  end

  assign op             = op_q;
  assign reg_write_data = wdata_q;
  assign alu_addr_1     = addr1_q;
  assign alu_addr_2     = addr2_q;
  assign alu_addr_3     = addr3_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_flags      = rsp_flags_q;
  assign rsp_tag        = rsp_tag_q;
  assign busy           = (state_q != S_IDLE) || (count_q != '0);
  assign cmd_count      = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a toy register file answers the default
// instance; a second instance is built with RESULT_LATENCY=3 for timing checks.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_op = 16'h0, cmd_data = 16'h0;
  logic [3:0]  cmd_addr_1 = 4'h0, cmd_addr_2 = 4'h0, cmd_addr_3 = 4'h0, cmd_tag = 4'h0;
  logic [15:0] op, reg_write_data, reg_read_data, rsp_data;
  logic [3:0]  alu_addr_1, alu_addr_2, alu_addr_3, alu_flags, rsp_flags, rsp_tag;
  logic        rsp_valid, busy;
  logic        rsp_ready = 1'b1;
  logic [2:0]  cmd_count;

  logic        c3_valid = 1'b0;
  logic        c3_ready;
  logic [15:0] c3_op = 16'h2000;
  logic [3:0]  c3_tag = 4'h0;
  logic [15:0] op3, wdata3, rdata3;
  logic [3:0]  a1_3, a2_3, a3_3, rflags3, rtag3;
  logic        rvalid3, busy3;
  logic [2:0]  count3;

  int total = 0;
  int bad = 0;
  int op_cycles = 0;
  int cyc = 0;

  alu_cmd_sequencer u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_addr_1(cmd_addr_1), .cmd_addr_2(cmd_addr_2), .cmd_addr_3(cmd_addr_3), .cmd_tag(cmd_tag),
    .op(op), .reg_write_data(reg_write_data),
    .alu_addr_1(alu_addr_1), .alu_addr_2(alu_addr_2), .alu_addr_3(alu_addr_3),
    .reg_read_data(reg_read_data), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy), .cmd_count(cmd_count)
  );

  alu_cmd_sequencer #(.RESULT_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op), .cmd_data(16'h0),
    .cmd_addr_1(4'h0), .cmd_addr_2(4'h0), .cmd_addr_3(4'h1), .cmd_tag(c3_tag),
    .op(op3), .reg_write_data(wdata3),
    .alu_addr_1(a1_3), .alu_addr_2(a2_3), .alu_addr_3(a3_3),
    .reg_read_data(16'h5A5A), .alu_flags(4'h0),
    .rsp_valid(rvalid3), .rsp_ready(1'b1), .rsp_data(rdata3),
    .rsp_flags(rflags3), .rsp_tag(rtag3), .busy(busy3), .cmd_count(count3)
  );

  // Toy register file: 16'h1000 writes data, 16'h0000 adds; bit1 of flags = result nonzero.
  logic [15:0] mem [16];
  logic [3:0]  flags_q;
  logic [15:0] sum;
  assign sum           = mem[alu_addr_1] + mem[alu_addr_2];
  assign reg_read_data = mem[alu_addr_3];
  assign alu_flags     = flags_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
      mem[1]  <= 16'd3;
      mem[2]  <= 16'd4;
      flags_q <= 4'h0;
    end else if (op == 16'h1000) begin
      mem[alu_addr_3] <= reg_write_data;
    end else if (op == 16'h0000) begin
      mem[alu_addr_3] <= sum;
      flags_q         <= {2'b00, (sum != 16'h0), 1'b0};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (op !== 16'hF000) op_cycles <= op_cycles + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push(input logic [15:0] o, input logic [15:0] d, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [3:0] a3, input logic [3:0] t);
    int n = 0;
    cmd_op = o; cmd_data = d; cmd_addr_1 = a1; cmd_addr_2 = a2; cmd_addr_3 = a3; cmd_tag = t;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [15:0] d, output logic [3:0] f, output logic [3:0] t);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
    d = rsp_data; f = rsp_flags; t = rsp_tag;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  f, t;
    int op0, n, exp_tag, stray, iss1, iss2, rspc;
    logic acc;

    // Reset, then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_op", 32'(op), 32'hF000);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_outs", {12'h0, rsp_data, alu_addr_3}, 32'h0);
    @(posedge clk); #1;

    // Write then read back through the register file
    op0 = op_cycles;
    push(16'h1000, 16'h00AB, 4'h0, 4'h0, 4'h5, 4'd3);
    push(16'h2000, 16'h0000, 4'h0, 4'h0, 4'h5, 4'd4);
    get_rsp(d, f, t);
    check("wr_tag", 32'(t), 32'd3);
    get_rsp(d, f, t);
    check("rd_data", 32'(d), 32'h00AB);
    check("rd_tag", 32'(t), 32'd4);
    check("op_once_each", 32'(op_cycles - op0), 32'd2);

    // ALU add: addresses held ISSUE..CAPTURE, result in the following cycle
    push(16'h0000, 16'h0000, 4'h1, 4'h2, 4'h6, 4'd9);
    n = 0;
    @(negedge clk);
    while (op !== 16'h0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("alu_issue_seen", 32'(op), 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("alu_addr_hold", 32'({alu_addr_1, alu_addr_2, alu_addr_3}), 32'h126);
      @(negedge clk);
    end
    check("alu_rsp_valid", 32'(rsp_valid), 32'd1);
    check("alu_flags", 32'(rsp_flags), 32'b0010);
    check("alu_data", 32'(rsp_data), 32'd7);
    check("alu_tag", 32'(rsp_tag), 32'd9);
    @(posedge clk); #1;

    // Backpressure: one command in RESP, FIFO fills to depth
    rsp_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(16'h2000, 16'h0, 4'h0, 4'h0, 4'(k), 4'(k));
    @(negedge clk);
    check("bp_ready", 32'(cmd_ready), 32'd0);
    check("bp_count", 32'(cmd_count), 32'd4);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_first_tag", 32'(rsp_tag), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_hold", 32'({rsp_valid, rsp_tag, cmd_ready}), 32'({1'b1, 4'd1, 1'b0}));
    @(posedge clk); #1;
    cmd_op = 16'h2000; cmd_addr_3 = 4'h6; cmd_tag = 4'd6; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    exp_tag = 1;
    n = 0;
    while (exp_tag <= 6 && n < 100) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        check("bp_order_tag", 32'(rsp_tag), 32'(exp_tag));
        exp_tag++;
      end
      @(posedge clk); #1;
      if (acc) cmd_valid = 1'b0;
      n++;
    end
    check("bp_all_returned", 32'(exp_tag), 32'd7);

    // Reset while the first command waits and two more are queued
    push(16'h2000, 16'h0, 4'h0, 4'h0, 4'h1, 4'd10);
    push(16'h2000, 16'h0, 4'h0, 4'h0, 4'h1, 4'd11);
    push(16'h2000, 16'h0, 4'h0, 4'h0, 4'h1, 4'd12);
    @(negedge clk);
    check("pre_rst_count", 32'(cmd_count), 32'd2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_count", 32'(cmd_count), 32'd0);
    check("mid_rst_op", 32'(op), 32'hF000);
    check("mid_rst_busy", 32'(busy), 32'd0);
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || op !== 16'hF000 || busy) stray++;
    end
    check("post_rst_quiet", 32'(stray), 32'd0);
    @(posedge clk); #1;

    // RESULT_LATENCY=3 instance, two back-to-back commands
    c3_tag = 4'd1; c3_valid = 1'b1;
    @(posedge clk); #1;
    c3_tag = 4'd2;
    @(posedge clk); #1;
    c3_valid = 1'b0;
    iss1 = -1; iss2 = -1; rspc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (op3 !== 16'hF000) begin
        if (iss1 < 0) iss1 = cyc;
        else if (iss2 < 0) iss2 = cyc;
      end
      if (rvalid3 && rspc < 0) begin
        rspc = cyc;
        check("l3_rsp_tag", 32'(rtag3), 32'd1);
      end
    end
    // Latency counted from the edge that hands the op to the ALU
    check("l3_issue_to_rsp", 32'(rspc - iss1 - 1), 32'd4);
    check("l3_spacing", 32'(iss2 - iss1), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
